// File: rtl/ex_operand_stage_if.sv
// Handshake and operand bus between decode, the EX operand stage and the ALU.
// The slave modport is the stage's view; master is the surrounding pipeline's view.
interface ex_operand_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [3:0]        in_alu_op;
    logic              in_is_float;
    logic [RD_W-1:0]   in_rd;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [3:0]        out_alu_op;
    logic              out_is_float;
    logic [RD_W-1:0]   out_rd;

    modport slave (
        input  in_valid, in_a, in_b, in_alu_op, in_is_float, in_rd, flush, out_ready,
        output in_ready, out_valid, out_a, out_b, out_alu_op, out_is_float, out_rd
    );

    modport master (
        output in_valid, in_a, in_b, in_alu_op, in_is_float, in_rd, flush, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_alu_op, out_is_float, out_rd
    );
endinterface

// File: rtl/ex_operand_stage.sv
// EX operand stage: two-entry skid buffer between decode and the ALU, fully registered outputs.
// Optional EX_OPERAND_STAGE_PERF_EN adds a saturating 16-bit output-stall counter.
module ex_operand_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef EX_OPERAND_STAGE_PERF_EN
    output logic [15:0]          stall_count,
`endif
    ex_operand_stage_if.slave    bus
);
    localparam int unsigned OP_W = 4;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   alu_op;
        logic              is_float;
        logic [RD_W-1:0]   rd;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t main_q, skid_q, in_entry;
    logic   in_ready_q, out_valid_q;
    logic   accept, consume;
    logic   load_main_in, load_main_skid, load_skid;

    assign in_entry = '{a: bus.in_a, b: bus.in_b, alu_op: bus.in_alu_op,
                        is_float: bus.in_is_float, rd: bus.in_rd};

    assign accept  = bus.in_valid && in_ready_q;
    assign consume = out_valid_q && bus.out_ready;

    // Next-state and register load selects; flush overrides every transition.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d      = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (consume) begin
                        state_d        = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // in_ready and out_valid are derived from the next state so both stay registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
            if (load_main_in) begin
                main_q <= in_entry;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
        end
    end

`ifdef EX_OPERAND_STAGE_PERF_EN
    // Counts cycles the ALU side withholds out_ready; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count <= 16'd0;
        end else if (out_valid_q && !bus.out_ready && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_a        = main_q.a;
    assign bus.out_b        = main_q.b;
    assign bus.out_alu_op   = main_q.alu_op;
    assign bus.out_is_float = main_q.is_float;
    assign bus.out_rd       = main_q.rd;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed self-checking bench for ex_operand_stage (honours EX_OPERAND_STAGE_PERF_EN).
module tb_ex_operand_stage;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_W   = 5;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
`ifdef EX_OPERAND_STAGE_PERF_EN
    logic [15:0] stall_count;
`endif

    ex_operand_stage_if #(.DATA_W(DATA_W), .RD_W(RD_W)) bus ();

    ex_operand_stage #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef EX_OPERAND_STAGE_PERF_EN
        .stall_count (stall_count),
`endif
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic fl, input logic [4:0] rd);
        bus.in_valid    = v;
        bus.in_a        = a;
        bus.in_b        = b;
        bus.in_alu_op   = op;
        bus.in_is_float = fl;
        bus.in_rd       = rd;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 5'd0);
        step();
        step();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_a", bus.out_a, 32'd0);
        chk("rst_out_b", bus.out_b, 32'd0);
        chk("rst_out_op", 32'(bus.out_alu_op), 32'd0);
        chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Pass-through with out_ready held high
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h10, 32'h20, 4'b0001, 1'b0, 5'd3);
        step();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 5'd0);
        chk("pt_valid", 32'(bus.out_valid), 32'd1);
        chk("pt_a", bus.out_a, 32'h10);
        chk("pt_b", bus.out_b, 32'h20);
        chk("pt_op", 32'(bus.out_alu_op), 32'h1);
        chk("pt_rd", 32'(bus.out_rd), 32'd3);
        step();
        chk("pt_drain", 32'(bus.out_valid), 32'd0);

        // Streaming: accept and consume in the same cycle keeps state ONE
        drive(1'b1, 32'hA, 32'hB, 4'b0010, 1'b0, 5'd7);
        step();
        chk("st_first_a", bus.out_a, 32'hA);
        drive(1'b1, 32'hC, 32'hD, 4'b0110, 1'b0, 5'd8);
        step();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 5'd0);
        chk("st_second_a", bus.out_a, 32'hC);
        chk("st_second_op", 32'(bus.out_alu_op), 32'h6);
        chk("st_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        chk("st_drain", 32'(bus.out_valid), 32'd0);

        // Backpressure: two ops fill main and skid
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h1, 32'h11, 4'b0110, 1'b0, 5'd1);
        step();
        chk("bp_ready_one", 32'(bus.in_ready), 32'd1);
        chk("bp_op_one", 32'(bus.out_alu_op), 32'h6);
        drive(1'b1, 32'h2, 32'h22, 4'b0111, 1'b0, 5'd2);
        step();
        drive(1'b1, 32'h99, 32'h99, 4'b0001, 1'b0, 5'd9);
        chk("bp_ready_full", 32'(bus.in_ready), 32'd0);
        chk("bp_hold_op", 32'(bus.out_alu_op), 32'h6);
        step();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 5'd0);
        chk("bp_stall_a", bus.out_a, 32'h1);
        chk("bp_stall_rd", 32'(bus.out_rd), 32'd1);
        bus.out_ready = 1'b1;
        step();
        chk("bp_second_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_second_op", 32'(bus.out_alu_op), 32'h7);
        chk("bp_second_b", bus.out_b, 32'h22);
        chk("bp_ready_back", 32'(bus.in_ready), 32'd1);
        step();
        chk("bp_drain", 32'(bus.out_valid), 32'd0);

        // Float operands pass bit-exact
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h3F800000, 32'h40000000, 4'b0001, 1'b1, 5'd5);
        step();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 5'd0);
        chk("fp_is_float", 32'(bus.out_is_float), 32'd1);
        chk("fp_a", bus.out_a, 32'h3F800000);
        chk("fp_b", bus.out_b, 32'h40000000);
        bus.out_ready = 1'b1;
        step();
        chk("fp_drain", 32'(bus.out_valid), 32'd0);

        // Flush while FULL with a concurrent op 1010
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h5, 32'h6, 4'b0010, 1'b0, 5'd4);
        step();
        drive(1'b1, 32'h7, 32'h8, 4'b0001, 1'b0, 5'd6);
        step();
        chk("fl_full", 32'(bus.in_ready), 32'd0);
        bus.flush = 1'b1;
        drive(1'b1, 32'hEE, 32'hEE, 4'b1010, 1'b0, 5'd10);
        step();
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 5'd0);
        chk("fl_valid", 32'(bus.out_valid), 32'd0);
        chk("fl_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_no_emit", 32'(bus.out_valid), 32'd0);
        end

        // Flush in ONE discards a handshake accepted in the same cycle
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h31, 32'h32, 4'b0111, 1'b0, 5'd12);
        step();
        bus.flush = 1'b1;
        drive(1'b1, 32'hEF, 32'hEF, 4'b1010, 1'b0, 5'd13);
        step();
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 5'd0);
        chk("fl1_valid", 32'(bus.out_valid), 32'd0);
        chk("fl1_ready", 32'(bus.in_ready), 32'd1);

        // Reset while FULL (also with flush asserted) drops everything
        drive(1'b1, 32'h41, 32'h42, 4'b0110, 1'b1, 5'd14);
        step();
        drive(1'b1, 32'h43, 32'h44, 4'b0111, 1'b0, 5'd15);
        step();
        chk("rf_full", 32'(bus.in_ready), 32'd0);
        rst_n     = 1'b0;
        bus.flush = 1'b1;
        step();
        rst_n     = 1'b1;
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 5'd0);
        chk("rf_valid", 32'(bus.out_valid), 32'd0);
        chk("rf_ready", 32'(bus.in_ready), 32'd1);
        chk("rf_a", bus.out_a, 32'd0);
        chk("rf_b", bus.out_b, 32'd0);
        chk("rf_op", 32'(bus.out_alu_op), 32'd0);
        chk("rf_fl", 32'(bus.out_is_float), 32'd0);
        chk("rf_rd", 32'(bus.out_rd), 32'd0);
        step();
        chk("rf_stays_empty", 32'(bus.out_valid), 32'd0);

`ifdef EX_OPERAND_STAGE_PERF_EN
        chk("perf_reset", 32'(stall_count), 32'd0);
        drive(1'b1, 32'h51, 32'h52, 4'b0001, 1'b0, 5'd16);
        step();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 5'd0);
        chk("perf_accept", 32'(stall_count), 32'd0);
        for (int i = 0; i < 5; i++) step();
        chk("perf_five", 32'(stall_count), 32'd5);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("perf_flush_keeps", 32'(stall_count), 32'd6);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 Parameter DATA_W, default 32, operand width for a/b paths.
REQ-002 Parameter RD_W, default 5, destination register index width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  upstream (decode) presents an operation.
REQ-006 in_ready  output  1  stage can accept; transfer when in_valid && in_ready.
REQ-007 in_a, in_b  input  DATA_W each  operands for the ALU.
REQ-008 in_alu_op  input  4  ALU opcode (0001 add, 0010 sub, 0110 and, 0111 or, 1010 slt).
REQ-009 in_is_float  input  1  selects floating-point ALU path.
REQ-010 in_rd  input  RD_W  destination register index.
REQ-011 flush  input  1  discard all held operations (branch/exception).
REQ-012 out_valid  output  1  operation presented to the ALU.
REQ-013 out_ready  input  1  ALU/EX side consumes; transfer when out_valid && out_ready.
REQ-014 out_a, out_b, out_alu_op, out_is_float, out_rd  output  DATA_W/DATA_W/4/1/RD_W  registered copy of accepted operation.

Function
REQ-015 Block SHALL be a 2-entry skid buffer: main register drives outputs, skid register holds one overflow entry.
REQ-016 States SHALL be EMPTY (none valid), ONE (main valid), FULL (main+skid valid).
REQ-017 in_ready SHALL be a registered signal equal to !(state==FULL); no combinational path from out_ready to in_ready.
REQ-018 Latency: operation accepted at edge N SHALL appear on out_* with out_valid=1 after edge N (one cycle).
REQ-019 EMPTY: accept -> ONE.
REQ-020 ONE: accept && consume -> ONE with new entry in main; accept && !consume -> FULL, new entry into skid; !accept && consume -> EMPTY; neither -> ONE.
REQ-021 FULL: consume -> ONE, skid moves to main, skid cleared; no accept possible.
REQ-022 While out_valid && !out_ready, all out_* SHALL hold stable.
REQ-023 Order SHALL be preserved; no entry dropped or duplicated absent flush.
REQ-024 flush SHALL, at the next edge, clear both entries -> EMPTY, in_ready=1, out_valid=0; an input handshake in the same cycle is discarded; flush has priority over all transitions.
REQ-025 Data registers SHALL load only on capture; out_* data when out_valid=0 is don't-care except after reset.
REQ-026 Fields pass unmodified; no width conversion or sign extension.

Reset
REQ-027 When rst_n=0 at an edge: state EMPTY, out_valid=0, in_ready=1, out_a/out_b=0, out_alu_op=0, out_is_float=0, out_rd=0, skid cleared.
REQ-028 Reset mid-operation SHALL drop held entries; reset has priority over flush and handshakes.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-030 Macro EX_OPERAND_STAGE_PERF_EN: when defined, adds output stall_count (16-bit) incrementing each cycle out_valid && !out_ready, saturating at 0xFFFF, cleared by reset only (not flush).
REQ-031 Without EX_OPERAND_STAGE_PERF_EN, stall_count port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 Pass-through: out_ready=1, send a=0x10,b=0x20,op=0001,rd=3 -> next cycle out_valid=1, out_a=0x10, out_b=0x20, out_alu_op=0001, out_rd=3.
REQ-033 Backpressure: out_ready=0, send two ops (op 0110 then 0111) -> in_ready=0 after second; out holds 0110 op; raise out_ready -> 0110 then 0111 emitted in order, in_ready returns 1.
REQ-034 Float op: a=0x3F800000,b=0x40000000,op=0001,is_float=1 -> out_is_float=1, operands bit-exact.
REQ-035 Flush while FULL with concurrent in_valid (op 1010) -> next cycle out_valid=0, in_ready=1, op 1010 never emitted.
REQ-036 Reset while FULL -> all outputs zero, out_valid=0, in_ready=1; with PERF_EN, stall_count=0 and 5 stalled cycles give stall_count=5.
